layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Frame-level controller for one fully-connected layer of `NUM_NEURONS` parallel `neuron` instances. Accepts an input vector as a valid/ready stream, broadcasts each element to every neuron with a one-cycle `input_valid` strobe, collects each neuron's result, and streams the results downstream in neuron-index order. Between the layer's input buffer and the next layer (or the argmax stage), it owns the neuron reset and sequencing so neurons never see overlapping frames.

## Interface
- `NUM_INPUTS`, 4, elements per input vector (≥2)
- `NUM_NEURONS`, 4, neurons driven in parallel (≥1)
- `DATAWIDTH`, 16, data/result width
- `TIMEOUT_CYCLES`, 64, WAIT-state watchdog limit (used only with `LAYER_SEQ_TIMEOUT_EN`)

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `in_data`  in  DATAWIDTH  input vector element
- `in_valid`  in  1  upstream element valid
- `in_ready`  out  1  sequencer accepts element
- `nrn_rst`  out  1  active-high reset to all neurons
- `nrn_input_val`  out  DATAWIDTH  broadcast element
- `nrn_input_valid`  out  1  broadcast strobe
- `nrn_out`  in  NUM_NEURONS*DATAWIDTH  neuron results, neuron k at bits [k*DATAWIDTH +: DATAWIDTH]
- `nrn_out_valid`  in  NUM_NEURONS  per-neuron result valid (pulse or level)
- `out_data`  out  DATAWIDTH  result element
- `out_idx`  out  $clog2(NUM_NEURONS) (min 1)  neuron index of `out_data`
- `out_valid`  out  1  result valid
- `out_last`  out  1  final result of frame
- `out_ready`  in  1  downstream accepts
- `busy`  out  1  high in any state except FEED with `in_cnt`==0
- `timeout_err`  out  1  sticky watchdog flag (0 without macro)

## Operation
- FSM states: CLEAR, FEED, WAIT, DRAIN.
- CLEAR: `nrn_rst`=1 for exactly one cycle; clears `in_cnt`, done bits, capture regs, `out_idx`. Next state is FEED.
- FEED: `in_ready`=1. On `in_valid && in_ready`, register `in_data` into `nrn_input_val` and pulse `nrn_input_valid` for one cycle; `in_cnt`++. On the beat with `in_cnt`==NUM_INPUTS-1, move to WAIT (`in_ready`=0 from the next cycle).
- WAIT: for each k with `nrn_out_valid[k]`=1 and `done[k]`=0, capture `nrn_out[k]` and set `done[k]`. Later assertions for a captured k are ignored. When all done bits are set (including any set this cycle), move to DRAIN.
- DRAIN: `out_valid`=1, `out_data`=cap[`out_idx`], `out_last`=(`out_idx`==NUM_NEURONS-1). On `out_valid && out_ready`, `out_idx`++; on the last handshake, move to CLEAR.
- `nrn_out_valid` seen outside WAIT is ignored.
- Data is passed through unmodified; no arithmetic on results.

## Timing
- Reset (`rst`=0 at a clock edge): state←CLEAR. All outputs are 0 except `nrn_rst`=1 and `busy`=1, and stay so while `rst`=0. A partial frame is discarded. `timeout_err` is cleared only by `rst`.
- First FEED cycle is 1 cycle after `rst` is released.
- Input latency: accepted beat → `nrn_input_valid` high on the next cycle. Back-to-back beats give a continuous strobe for NUM_INPUTS cycles.
- WAIT→DRAIN: `out_valid` is asserted the cycle after the last done bit is set.
- `out_data`/`out_idx`/`out_last` stay stable while `out_valid && !out_ready`.
- Frame turnaround: last output handshake → CLEAR (1 cycle) → FEED. Minimum frame period is NUM_INPUTS + 1 + (neuron latency) + 1 + NUM_NEURONS + 1 cycles.

## Configuration
- `LAYER_SEQ_TIMEOUT_EN` defined:
  - Watchdog counter runs in WAIT and resets on WAIT entry.
  - When it reaches TIMEOUT_CYCLES with any done bit clear: set `timeout_err`, leave uncaptured results at 0, and move to DRAIN.
  - Frame completes normally otherwise.
- `LAYER_SEQ_TIMEOUT_EN` undefined:
  - No counter; WAIT holds until all done bits are set.
  - `timeout_err` is tied to 0.

## Test plan
- Reset, then 4 elements 1,2,3,4 with `in_valid` held high → `nrn_input_valid` high 4 consecutive cycles carrying 1,2,3,4; `in_ready` low after 4th beat.
- Neurons return 10,20,30,40 with `out_valid` pulses in order 3,0,2,1 over separate cycles → outputs 10,20,30,40 with `out_idx` 0..3, `out_last` only on 40.
- `out_ready` low for 5 cycles mid-drain at idx 1 → `out_data`=20 held stable; resumes with 30,40; then exactly one `nrn_rst` pulse, then `in_ready`=1.
- `rst`=0 after 2 of 4 input beats → all outputs 0 except `nrn_rst`/`busy`; after release, a fresh full frame 5,6,7,8 processes correctly.
- With `LAYER_SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES=64, neuron 2 never valid → DRAIN after 64 WAIT cycles, outputs 10,20,0,40, `timeout_err`=1 sticky into the next frame.
- Without the macro, same stimulus → no `out_valid` for 200 cycles, `timeout_err`=0.

Source files
------------

// File: rtl/layer_sequencer.sv
// Sequences one FC layer: broadcast inputs, collect per-neuron results, drain in index order.
// Latency: input beat -> strobe 1 cycle; last result captured -> out_valid 1 cycle. Optional watchdog: LAYER_SEQ_TIMEOUT_EN.
// Backpressure: in_ready only in FEED; DRAIN holds out_* stable while out_ready is low.
module layer_sequencer #(
  parameter int NUM_INPUTS     = 4,
  parameter int NUM_NEURONS    = 4,
  parameter int DATAWIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IDXW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATAWIDTH-1:0]             in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             nrn_rst,
  output logic [DATAWIDTH-1:0]             nrn_input_val,
  output logic                             nrn_input_valid,
  input  logic [NUM_NEURONS*DATAWIDTH-1:0] nrn_out,
  input  logic [NUM_NEURONS-1:0]           nrn_out_valid,
  output logic [DATAWIDTH-1:0]             out_data,
  output logic [IDXW-1:0]                  out_idx,
  output logic                             out_valid,
  output logic                             out_last,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int CNTW = $clog2(NUM_INPUTS);

  typedef enum logic [1:0] {CLEAR, FEED, WAIT, DRAIN} state_t;

  state_t                 state;
  logic [CNTW-1:0]        in_cnt;
  logic [NUM_NEURONS-1:0] done;
  logic [NUM_NEURONS-1:0] done_nxt;
  logic [DATAWIDTH-1:0]   cap [NUM_NEURONS];
  logic                   wdog_hit;

  assign done_nxt = done | nrn_out_valid;
  assign out_data = cap[out_idx];
  assign out_last = out_valid && (out_idx == IDXW'(NUM_NEURONS - 1));

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wdog;
  logic           timeout_r;

  assign wdog_hit    = (state == WAIT) && (wdog == WDW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_r;

  // Counter is held at zero outside WAIT, so every WAIT entry starts a fresh window.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog      <= '0;
      timeout_r <= 1'b0;
    end else if (state != WAIT) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + WDW'(1);
      if (wdog_hit && !(&done_nxt))
        timeout_r <= 1'b1;
    end
  end
`else
  assign wdog_hit    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= CLEAR;
      in_cnt          <= '0;
      done            <= '0;
      in_ready        <= 1'b0;
      nrn_rst         <= 1'b1;
      nrn_input_val   <= '0;
      nrn_input_valid <= 1'b0;
      out_idx         <= '0;
      out_valid       <= 1'b0;
      busy            <= 1'b1;
      for (int k = 0; k < NUM_NEURONS; k++)
        cap[k] <= '0;
    end else begin
      nrn_input_valid <= 1'b0;
      case (state)
        CLEAR: begin
          in_cnt   <= '0;
          done     <= '0;
          out_idx  <= '0;
          for (int k = 0; k < NUM_NEURONS; k++)
            cap[k] <= '0;
          nrn_rst  <= 1'b0;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= FEED;
        end
        FEED: begin
          if (in_valid) begin
            nrn_input_val   <= in_data;
            nrn_input_valid <= 1'b1;
            busy            <= 1'b1;
            if (in_cnt == CNTW'(NUM_INPUTS - 1)) begin
              in_ready <= 1'b0;
              state    <= WAIT;
            end else begin
              in_cnt <= in_cnt + CNTW'(1);
            end
          end
        end
        WAIT: begin
          // First assertion per neuron wins; repeats are ignored via the done mask.
          for (int k = 0; k < NUM_NEURONS; k++)
            if (nrn_out_valid[k] && !done[k])
              cap[k] <= nrn_out[k*DATAWIDTH +: DATAWIDTH];
          done <= done_nxt;
          if ((&done_nxt) || wdog_hit) begin
            out_valid <= 1'b1;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_idx == IDXW'(NUM_NEURONS - 1)) begin
              out_valid <= 1'b0;
              nrn_rst   <= 1'b1;
              state     <= CLEAR;
            end else begin
              out_idx <= out_idx + IDXW'(1);
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: table-driven feed phase plus output scoreboard.
module tb_layer_sequencer;

  localparam int NI = 4;
  localparam int NN = 4;
  localparam int DW = 16;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic              nrn_rst;
  logic [DW-1:0]     nrn_input_val;
  logic              nrn_input_valid;
  logic [NN*DW-1:0]  nrn_out;
  logic [NN-1:0]     nrn_out_valid;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_idx;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              timeout_err;

  layer_sequencer #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATAWIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .nrn_rst(nrn_rst), .nrn_input_val(nrn_input_val), .nrn_input_valid(nrn_input_valid),
    .nrn_out(nrn_out), .nrn_out_valid(nrn_out_valid),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    idx;
    logic          last;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic          rst_n;
    logic          iv;
    logic [DW-1:0] d;
    logic          e_ready;
    logic          e_niv;
    logic [DW-1:0] e_nval;
    logic          e_nrst;
    logic          e_busy;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nrn(input int k, input logic [DW-1:0] v);
    nrn_out[k*DW +: DW] = v;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [1:0] i, input logic l);
    exp_t e;
    e.data = d; e.idx = i; e.last = l;
    sb.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_nrn_rst"}, nrn_rst, 1);
    chk({tag, "_nrn_input_val"}, nrn_input_val, 0);
    chk({tag, "_nrn_input_valid"}, nrn_input_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // Output scoreboard: every accepted result must match the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got data %0h idx %0d, expected none", out_data, out_idx);
      end else begin
        e = sb.pop_front();
        chk("sb_out_data", out_data, e.data);
        chk("sb_out_idx", out_idx, e.idx);
        chk("sb_out_last", out_last, e.last);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    vt[0] = '{1'b1, 1'b0, 16'd0,  1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 16'd1,  1'b1, 1'b1, 16'd1, 1'b0, 1'b1};
    vt[2] = '{1'b1, 1'b1, 16'd2,  1'b1, 1'b1, 16'd2, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 16'd3,  1'b1, 1'b1, 16'd3, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 16'd4,  1'b0, 1'b1, 16'd4, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b1, 16'd99, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 16'd0, 1'b0, 1'b1};

    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    nrn_out = '0; nrn_out_valid = '0; out_ready = 1'b1;
    repeat (3) tick();
    check_reset("por");

    // Frame 1 feed phase from the vector table
    for (int i = 0; i < 7; i++) begin
      rst = vt[i].rst_n; in_valid = vt[i].iv; in_data = vt[i].d;
      tick();
      chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].e_ready);
      chk($sformatf("v%0d_niv", i), nrn_input_valid, vt[i].e_niv);
      if (vt[i].e_niv) chk($sformatf("v%0d_nval", i), nrn_input_val, vt[i].e_nval);
      chk($sformatf("v%0d_nrn_rst", i), nrn_rst, vt[i].e_nrst);
      chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
    end
    in_valid = 1'b0;

    // Results arrive out of order; drain must be in index order
    set_nrn(0, 16'd10); set_nrn(1, 16'd20); set_nrn(2, 16'd30); set_nrn(3, 16'd40);
    push(16'd10, 2'd0, 1'b0); push(16'd20, 2'd1, 1'b0);
    push(16'd30, 2'd2, 1'b0); push(16'd40, 2'd3, 1'b1);
    nrn_out_valid = 4'b1000; tick(); nrn_out_valid = '0;
    chk("w3_out_valid", out_valid, 0);
    set_nrn(3, 16'd77); nrn_out_valid = 4'b1000; tick(); nrn_out_valid = '0;
    chk("w3dup_out_valid", out_valid, 0);
    nrn_out_valid = 4'b0001; tick(); nrn_out_valid = '0;
    chk("w0_out_valid", out_valid, 0);
    tick();
    nrn_out_valid = 4'b0100; tick(); nrn_out_valid = '0;
    chk("w2_out_valid", out_valid, 0);
    nrn_out_valid = 4'b0010; tick(); nrn_out_valid = '0;
    chk("d0_out_valid", out_valid, 1);
    chk("d0_out_idx", out_idx, 0);
    chk("d0_out_data", out_data, 16'd10);
    tick();
    chk("d1_out_idx", out_idx, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall%0d_valid", i), out_valid, 1);
      chk($sformatf("stall%0d_data", i), out_data, 16'd20);
      chk($sformatf("stall%0d_idx", i), out_idx, 1);
      chk($sformatf("stall%0d_last", i), out_last, 0);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    chk("clr_nrn_rst", nrn_rst, 1);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 0);
    tick();
    chk("feed_nrn_rst", nrn_rst, 0);
    chk("feed_in_ready", in_ready, 1);
    chk("feed_busy", busy, 0);
    chk("f1_sb_empty", sb.size(), 0);

    // Partial frame interrupted by reset
    in_valid = 1'b1; in_data = 16'd11; tick();
    in_data = 16'd12; tick();
    rst = 1'b0; in_valid = 1'b0;
    tick(); check_reset("mid0");
    tick(); check_reset("mid1");
    rst = 1'b1; tick();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_busy", busy, 0);

    // Fresh frame; neuron valids asserted during FEED must be ignored
    nrn_out_valid = 4'hF;
    for (int k = 0; k < NN; k++) set_nrn(k, 16'hDEAD);
    in_valid = 1'b1;
    for (int v = 5; v <= 8; v++) begin
      in_data = DW'(v);
      tick();
      chk($sformatf("f2_niv_%0d", v), nrn_input_valid, 1);
      chk($sformatf("f2_nval_%0d", v), nrn_input_val, v);
    end
    in_valid = 1'b0; nrn_out_valid = '0;
    set_nrn(0, 16'd100); set_nrn(1, 16'd200); set_nrn(2, 16'd300); set_nrn(3, 16'd400);
    push(16'd100, 2'd0, 1'b0); push(16'd200, 2'd1, 1'b0);
    push(16'd300, 2'd2, 1'b0); push(16'd400, 2'd3, 1'b1);
    tick();
    chk("f2_wait_out_valid", out_valid, 0);
    nrn_out_valid = 4'hF; tick(); nrn_out_valid = '0;
    chk("f2_drain_valid", out_valid, 1);
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    chk("f2_sb_empty", sb.size(), 0);
    tick();
    chk("f2_next_in_ready", in_ready, 1);

    // Neuron 2 never responds
    in_valid = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      in_data = DW'(v);
      tick();
    end
    in_valid = 1'b0;
    set_nrn(0, 16'd10); set_nrn(1, 16'd20); set_nrn(2, 16'h3333); set_nrn(3, 16'd40);
    nrn_out_valid = 4'b1011; tick(); nrn_out_valid = '0;
`ifdef LAYER_SEQ_TIMEOUT_EN
    push(16'd10, 2'd0, 1'b0); push(16'd20, 2'd1, 1'b0);
    push(16'd0, 2'd2, 1'b0); push(16'd40, 2'd3, 1'b1);
    n = 1;
    while (out_valid !== 1'b1 && n < 150) begin
      tick();
      n++;
    end
    chk("to_wait_cycles", n, TO);
    chk("to_err_set", timeout_err, 1);
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    chk("to_sb_empty", sb.size(), 0);
    repeat (2) tick();
    chk("to_next_in_ready", in_ready, 1);
    chk("to_err_sticky", timeout_err, 1);
`else
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (out_valid === 1'b1) n++;
    end
    chk("nto_no_out_valid", n, 0);
    chk("nto_err_zero", timeout_err, 0);
    chk("nto_still_busy", busy, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
